multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
// Multi-cycle control sequencer for the RV32I core. It consumes the one-hot instruction-class flags
// from the opcode type decoder and steps the shared datapath (PC, IR, ALU, regfile, memories) through
// FETCH/DECODE/EXEC/MEM/WB. It owns the imem/dmem request handshakes, a memory-wait watchdog,
// a retired-instruction counter and a sticky trap state.
// PARAMETERS
// TIMEOUT   16  consecutive cycles a memory request may wait for ready before a trap; 0 = watchdog disabled
// CNT_W     32  width of the instret counter
// PORTS
// clk          in   1      clock, all state updates on rising edge
// rst          in   1      synchronous, active-high reset
// r_type,i_type,store,load,branch,jal,jalr,auipc,lui  in 1 each  decoder class flags, sampled in DECODE only
// branch_taken in   1      branch comparator result, sampled in EXEC
// imem_ready   in   1      instruction memory ack; instruction valid on IR input this cycle
// dmem_ready   in   1      data memory ack; load data valid / store committed this cycle
// imem_req     out  1      instruction fetch request
// dmem_req     out  1      data access request
// dmem_we      out  1      data write enable (valid with dmem_req)
// ir_we        out  1      IR load strobe
// pc_we        out  1      PC update strobe
// pc_sel       out  2      00 pc+4, 01 pc+imm (branch/jal), 10 (rs1+imm)&~1 (jalr)
// alu_a_sel    out  1      0 rs1, 1 pc
// alu_b_sel    out  1      0 rs2, 1 imm
// reg_we       out  1      regfile write strobe
// wb_sel       out  2      00 alu, 01 load data, 10 pc+4, 11 imm (lui)
// retire       out  1      one-cycle pulse per completed instruction
// instret      out  CNT_W  retired-instruction count
// trap         out  1      sticky; core halted
// trap_cause   out  2      00 none, 01 illegal opcode, 10 imem timeout, 11 dmem timeout
// BEHAVIOUR
// - States FETCH, DECODE, EXEC, MEM, WB, TRAP. Outputs decode combinationally from state + class reg.
// - Reset: state=FETCH, class reg=0, wait counter=0, instret=0, trap=0, trap_cause=00; every output 0
//   while rst=1. Mid-operation reset abandons any pending request without waiting for ready.
// - FETCH: imem_req=1 held until imem_ready; that cycle ir_we=1, -> DECODE.
// - DECODE: latch flags into class reg. No flag set -> TRAP, cause 01. Else -> EXEC.
// - EXEC: alu_a_sel=1 for auipc/jal/branch; alu_b_sel=1 for all but r_type/branch.
//   branch: pc_we=1, pc_sel=branch_taken?01:00, retire, -> FETCH.
//   load/store -> MEM; all others -> WB.
// - MEM: dmem_req=1, dmem_we=store; held until dmem_ready. load -> WB.
//   store: on ready pc_we=1, pc_sel=00, retire, -> FETCH.
// - WB: reg_we=1, pc_we=1, retire, -> FETCH. wb_sel: load 01, jal/jalr 10, lui 11, else 00.
//   pc_sel: jal 01, jalr 10, else 00. ALU selects held from EXEC.
// - Latency with ready in first request cycle: branch 3, store 4, ALU/lui/auipc/jal/jalr 4, load 5.
// - Watchdog: counter clears on state entry and on ready; increments each FETCH/MEM cycle without ready.
//   If TIMEOUT!=0 and it reaches TIMEOUT: -> TRAP, cause 10 (FETCH) or 11 (MEM).
//   Ready in the same cycle counter would hit TIMEOUT wins.
// - TRAP: all strobes/requests 0, trap=1, trap_cause held; exit only via rst.
// - instret increments by 1 on each retire, wraps modulo 2^CNT_W.
// - The retire pulse and instret update are in the same cycle as the final pc_we.
// TESTING
// 1. rst 2 cycles, then r_type flag, ready immediate -> imem_req cyc0, reg_we+pc_we+retire cyc3, instret=1.
// 2. load with dmem_ready delayed 3 cycles -> dmem_req held 4 cycles, dmem_we=0, WB wb_sel=01, total 8 cycles.
// 3. branch, branch_taken=1 then =0 -> EXEC pc_we with pc_sel=01 then 00; reg_we never asserted.
// 4. jalr -> WB reg_we, wb_sel=10, pc_sel=10; lui -> wb_sel=11, pc_sel=00.
// 5. all flags 0 in DECODE -> trap=1, cause=01, no further imem_req until rst; TIMEOUT=16 with
//    imem_ready stuck 0 -> trap cause=10 after 16 cycles.
// 6. rst asserted mid-MEM store -> dmem_req drops next cycle, instret=0, FETCH restarts; CNT_W=4 -> 16 retires wrap instret to 0.

Source files
------------

// File: rtl/multicycle_ctrl_if.sv
// Memory handshake bundle between the multi-cycle sequencer and the
// instruction/data memories.
//   imem_req   : instruction fetch request (sequencer -> imem)
//   imem_ready : fetch acknowledge, instruction valid this cycle (imem -> sequencer)
//   dmem_req   : data access request (sequencer -> dmem)
//   dmem_we    : data write enable, meaningful only with dmem_req
//   dmem_ready : data acknowledge, load data valid / store committed (dmem -> sequencer)
// master = sequencer side, slave = memory side.
interface multicycle_ctrl_if;
    logic imem_req;
    logic imem_ready;
    logic dmem_req;
    logic dmem_we;
    logic dmem_ready;

    modport master (
        output imem_req,
        output dmem_req,
        output dmem_we,
        input  imem_ready,
        input  dmem_ready
    );

    modport slave (
        input  imem_req,
        input  dmem_req,
        input  dmem_we,
        output imem_ready,
        output dmem_ready
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control sequencer for the RV32I core. Steps the shared datapath
// through FETCH/DECODE/EXEC/MEM/WB, owns the memory handshakes, a memory-wait
// watchdog, the retired-instruction counter and a sticky trap state.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   bus (master)         : imem/dmem request/ready handshake
//   r_type..lui          : one-hot instruction-class flags, sampled in DECODE
//   branch_taken         : branch comparator result, sampled in EXEC
//   ir_we, pc_we         : IR load / PC update strobes
//   pc_sel               : 00 pc+4, 01 pc+imm, 10 (rs1+imm)&~1
//   alu_a_sel, alu_b_sel : 0 rs1 / 1 pc ; 0 rs2 / 1 imm
//   reg_we, wb_sel       : regfile write strobe; 00 alu, 01 load, 10 pc+4, 11 imm
//   retire, instret      : retire pulse and retired-instruction count
//   trap, trap_cause     : sticky halt; 01 illegal, 10 imem timeout, 11 dmem timeout
module multicycle_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    multicycle_ctrl_if.master bus,
    input  logic             r_type,
    input  logic             i_type,
    input  logic             store,
    input  logic             load,
    input  logic             branch,
    input  logic             jal,
    input  logic             jalr,
    input  logic             auipc,
    input  logic             lui,
    input  logic             branch_taken,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic             alu_a_sel,
    output logic             alu_b_sel,
    output logic             reg_we,
    output logic [1:0]       wb_sel,
    output logic             retire,
    output logic [CNT_W-1:0] instret,
    output logic             trap,
    output logic [1:0]       trap_cause
);
    localparam int WAIT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
    } state_t;

    state_t             state_reg, state_next;
    logic [8:0]         class_reg, class_next;
    logic [WAIT_W-1:0]  wait_cnt_reg, wait_cnt_next;
    logic [CNT_W-1:0]   instret_reg, instret_next;
    logic [1:0]         trap_cause_reg, trap_cause_next;

    logic [8:0] flags_in;
    logic is_r, is_st, is_ld, is_br, is_jal, is_jalr, is_auipc, is_lui;
    logic timeout_hit;

    // Ungated combinational outputs; forced low while rst is high.
    logic imem_req_c, dmem_req_c, dmem_we_c, ir_we_c, pc_we_c, alu_a_c, alu_b_c;
    logic reg_we_c, retire_c, trap_c;
    logic [1:0] pc_sel_c, wb_sel_c;

    assign flags_in = {lui, auipc, jalr, jal, branch, load, store, i_type, r_type};

    assign is_r     = class_reg[0];
    assign is_st    = class_reg[2];
    assign is_ld    = class_reg[3];
    assign is_br    = class_reg[4];
    assign is_jal   = class_reg[5];
    assign is_jalr  = class_reg[6];
    assign is_auipc = class_reg[7];
    assign is_lui   = class_reg[8];

    // The counter only ever holds TIMEOUT-1 before the trap is taken, so the
    // wait that would make it TIMEOUT is the one that traps (unless ready).
    assign timeout_hit = (TIMEOUT != 0) && (wait_cnt_reg == WAIT_W'(TIMEOUT - 1));

    always_comb begin
        state_next      = state_reg;
        class_next      = class_reg;
        wait_cnt_next   = '0;
        instret_next    = instret_reg;
        trap_cause_next = trap_cause_reg;
        imem_req_c      = 1'b0;
        dmem_req_c      = 1'b0;
        dmem_we_c       = 1'b0;
        ir_we_c         = 1'b0;
        pc_we_c         = 1'b0;
        pc_sel_c        = 2'b00;
        alu_a_c         = 1'b0;
        alu_b_c         = 1'b0;
        reg_we_c        = 1'b0;
        wb_sel_c        = 2'b00;
        retire_c        = 1'b0;
        trap_c          = 1'b0;

        case (state_reg)
            S_FETCH: begin
                imem_req_c = 1'b1;
                if (bus.imem_ready) begin
                    ir_we_c    = 1'b1;
                    state_next = S_DECODE;
                end else if (timeout_hit) begin
                    trap_cause_next = 2'b10;
                    state_next      = S_TRAP;
                end else if (TIMEOUT != 0) begin
                    wait_cnt_next = wait_cnt_reg + WAIT_W'(1);
                end
            end
            S_DECODE: begin
                class_next = flags_in;
                if (flags_in == 9'd0) begin
                    trap_cause_next = 2'b01;
                    state_next      = S_TRAP;
                end else begin
                    state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                alu_a_c = is_auipc | is_jal | is_br;
                alu_b_c = ~(is_r | is_br);
                if (is_br) begin
                    pc_we_c    = 1'b1;
                    pc_sel_c   = branch_taken ? 2'b01 : 2'b00;
                    retire_c   = 1'b1;
                    state_next = S_FETCH;
                end else if (is_ld | is_st) begin
                    state_next = S_MEM;
                end else begin
                    state_next = S_WB;
                end
            end
            S_MEM: begin
                // Address path stays selected while the access is pending.
                alu_a_c    = 1'b0;
                alu_b_c    = 1'b1;
                dmem_req_c = 1'b1;
                dmem_we_c  = is_st;
                if (bus.dmem_ready) begin
                    if (is_st) begin
                        pc_we_c    = 1'b1;
                        retire_c   = 1'b1;
                        state_next = S_FETCH;
                    end else begin
                        state_next = S_WB;
                    end
                end else if (timeout_hit) begin
                    trap_cause_next = 2'b11;
                    state_next      = S_TRAP;
                end else if (TIMEOUT != 0) begin
                    wait_cnt_next = wait_cnt_reg + WAIT_W'(1);
                end
            end
            S_WB: begin
                alu_a_c  = is_auipc | is_jal | is_br;
                alu_b_c  = ~(is_r | is_br);
                reg_we_c = 1'b1;
                pc_we_c  = 1'b1;
                retire_c = 1'b1;
                if (is_ld)                 wb_sel_c = 2'b01;
                else if (is_jal | is_jalr) wb_sel_c = 2'b10;
                else if (is_lui)           wb_sel_c = 2'b11;
                if (is_jal)       pc_sel_c = 2'b01;
                else if (is_jalr) pc_sel_c = 2'b10;
                state_next = S_FETCH;
            end
            S_TRAP: begin
                trap_c = 1'b1;
            end
            default: begin
                state_next = S_FETCH;
            end
        endcase

        if (retire_c) begin
            instret_next = instret_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= S_FETCH;
            class_reg      <= '0;
            wait_cnt_reg   <= '0;
            instret_reg    <= '0;
            trap_cause_reg <= 2'b00;
        end else begin
            state_reg      <= state_next;
            class_reg      <= class_next;
            wait_cnt_reg   <= wait_cnt_next;
            instret_reg    <= instret_next;
            trap_cause_reg <= trap_cause_next;
        end
    end

    // Everything is held low during reset so a pending request is dropped at once.
    assign bus.imem_req = imem_req_c & ~rst;
    assign bus.dmem_req = dmem_req_c & ~rst;
    assign bus.dmem_we  = dmem_we_c  & ~rst;
    assign ir_we        = ir_we_c    & ~rst;
    assign pc_we        = pc_we_c    & ~rst;
    assign pc_sel       = rst ? 2'b00 : pc_sel_c;
    assign alu_a_sel    = alu_a_c    & ~rst;
    assign alu_b_sel    = alu_b_c    & ~rst;
    assign reg_we       = reg_we_c   & ~rst;
    assign wb_sel       = rst ? 2'b00 : wb_sel_c;
    assign retire       = retire_c   & ~rst;
    assign instret      = rst ? '0 : instret_reg;
    assign trap         = trap_c     & ~rst;
    assign trap_cause   = rst ? 2'b00 : trap_cause_reg;
endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [8:0] flags;
    logic       branch_taken;
    logic       ir_we, pc_we, alu_a_sel, alu_b_sel, reg_we, retire, trap;
    logic [1:0] pc_sel, wb_sel, trap_cause;
    logic [3:0] instret;

    multicycle_ctrl_if bus();

    multicycle_ctrl #(.TIMEOUT(16), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .r_type(flags[0]), .i_type(flags[1]), .store(flags[2]), .load(flags[3]),
        .branch(flags[4]), .jal(flags[5]), .jalr(flags[6]), .auipc(flags[7]), .lui(flags[8]),
        .branch_taken(branch_taken),
        .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel),
        .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel),
        .reg_we(reg_we), .wb_sel(wb_sel), .retire(retire),
        .instret(instret), .trap(trap), .trap_cause(trap_cause)
    );

    // class index: 0 r_type 1 i_type 2 store 3 load 4 branch 5 jal 6 jalr 7 auipc 8 lui
    typedef struct {
        logic imem_req, dmem_req, dmem_we, ir_we, pc_we;
        logic [1:0] pc_sel;
        logic alu_a, alu_b, reg_we;
        logic [1:0] wb_sel;
        logic retire, trap;
    } outs_t;

    typedef struct {
        logic  imem_ready;
        logic  dmem_ready;
        logic  chk_alu;
        outs_t e;
    } cyc_t;

    typedef struct {
        int cls; bit taken; int idly; int ddly;
        int lat; logic rwe; logic [1:0] wsel; logic [1:0] psel;
    } vec_t;

    localparam logic [13:0] ALU_BITS = 14'h0060;

    int total = 0;
    int bad = 0;
    int model_instret = 0;

    function automatic logic [13:0] pack(input outs_t o);
        return {o.imem_req, o.dmem_req, o.dmem_we, o.ir_we, o.pc_we, o.pc_sel,
                o.alu_a, o.alu_b, o.reg_we, o.wb_sel, o.retire, o.trap};
    endfunction

    function automatic logic [13:0] obs();
        return {bus.imem_req, bus.dmem_req, bus.dmem_we, ir_we, pc_we, pc_sel,
                alu_a_sel, alu_b_sel, reg_we, wb_sel, retire, trap};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, act, want);
        end
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1; flags = '0; branch_taken = 1'b0;
        bus.imem_ready = 1'b0; bus.dmem_ready = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("reset_outputs", {14'(obs()), instret, trap_cause}, 32'd0);
            @(posedge clk); #1;
        end
        rst = 1'b0;
        model_instret = 0;
    endtask

    // Expected behaviour of one instruction, built phase by phase from the
    // instruction-class rules: fetch wait, decode, execute, optional memory
    // wait, optional writeback.
    task automatic run_instr(input int cls, input bit taken, input int idly, input int ddly,
                             output int lat, output logic rwe,
                             output logic [1:0] wsel, output logic [1:0] psel);
        cyc_t q[$];
        cyc_t c;
        outs_t z;
        logic [13:0] act, want, mask;
        bit is_br, is_ld, is_st, is_mem, has_wb, a_pc, b_imm;
        z = '{default: 1'b0};
        is_br  = (cls == 4);
        is_ld  = (cls == 3);
        is_st  = (cls == 2);
        is_mem = is_ld || is_st;
        has_wb = !is_br && !is_st;
        a_pc   = (cls == 7) || (cls == 5) || is_br;
        b_imm  = !((cls == 0) || is_br);

        for (int i = 0; i <= idly; i++) begin
            c = '{imem_ready: (i == idly), dmem_ready: 1'b0, chk_alu: 1'b0, e: z};
            c.e.imem_req = 1'b1;
            c.e.ir_we    = (i == idly);
            q.push_back(c);
        end
        c = '{imem_ready: 1'b0, dmem_ready: 1'b0, chk_alu: 1'b0, e: z};
        q.push_back(c);
        c = '{imem_ready: 1'b0, dmem_ready: 1'b0, chk_alu: 1'b1, e: z};
        c.e.alu_a = a_pc; c.e.alu_b = b_imm;
        if (is_br) begin
            c.e.pc_we = 1'b1; c.e.pc_sel = taken ? 2'b01 : 2'b00; c.e.retire = 1'b1;
        end
        q.push_back(c);
        if (is_mem) begin
            for (int i = 0; i <= ddly; i++) begin
                c = '{imem_ready: 1'b0, dmem_ready: (i == ddly), chk_alu: 1'b0, e: z};
                c.e.dmem_req = 1'b1; c.e.dmem_we = is_st;
                if (is_st && i == ddly) begin
                    c.e.pc_we = 1'b1; c.e.retire = 1'b1;
                end
                q.push_back(c);
            end
        end
        if (has_wb) begin
            c = '{imem_ready: 1'b0, dmem_ready: 1'b0, chk_alu: 1'b1, e: z};
            c.e.alu_a = a_pc; c.e.alu_b = b_imm;
            c.e.reg_we = 1'b1; c.e.pc_we = 1'b1; c.e.retire = 1'b1;
            c.e.wb_sel = is_ld ? 2'b01 : (cls == 5 || cls == 6) ? 2'b10 : (cls == 8) ? 2'b11 : 2'b00;
            c.e.pc_sel = (cls == 5) ? 2'b01 : (cls == 6) ? 2'b10 : 2'b00;
            q.push_back(c);
        end

        flags = 9'(1 << cls);
        branch_taken = taken;
        lat = 0; rwe = 1'b0; wsel = 2'b00; psel = 2'b00;
        foreach (q[k]) begin
            bus.imem_ready = q[k].imem_ready;
            bus.dmem_ready = q[k].dmem_ready;
            @(negedge clk);
            act  = obs();
            want = pack(q[k].e);
            mask = q[k].chk_alu ? 14'h3fff : ~ALU_BITS;
            total++;
            if ((act & mask) !== (want & mask)) begin
                bad++;
                $display("FAIL cycle cls=%0d k=%0d got=%b want=%b", cls, k, act & mask, want & mask);
            end
            if (retire && lat == 0) begin
                lat = k + 1; rwe = reg_we; wsel = wb_sel; psel = pc_sel;
            end
            @(posedge clk); #1;
        end
        bus.imem_ready = 1'b0; bus.dmem_ready = 1'b0;
        model_instret = (model_instret + 1) % 16;
        check("instret", 32'(instret), 32'(model_instret));
    endtask

    vec_t tbl[13];
    int lat;
    logic rwe;
    logic [1:0] wsel, psel;
    int n, first_trap;

    initial begin
        tbl[0]  = '{0, 1'b0, 0, 0, 4, 1'b1, 2'b00, 2'b00};
        tbl[1]  = '{1, 1'b0, 0, 0, 4, 1'b1, 2'b00, 2'b00};
        tbl[2]  = '{2, 1'b0, 0, 0, 4, 1'b0, 2'b00, 2'b00};
        tbl[3]  = '{3, 1'b0, 0, 0, 5, 1'b1, 2'b01, 2'b00};
        tbl[4]  = '{4, 1'b1, 0, 0, 3, 1'b0, 2'b00, 2'b01};
        tbl[5]  = '{4, 1'b0, 0, 0, 3, 1'b0, 2'b00, 2'b00};
        tbl[6]  = '{5, 1'b0, 0, 0, 4, 1'b1, 2'b10, 2'b01};
        tbl[7]  = '{6, 1'b0, 0, 0, 4, 1'b1, 2'b10, 2'b10};
        tbl[8]  = '{7, 1'b0, 0, 0, 4, 1'b1, 2'b00, 2'b00};
        tbl[9]  = '{8, 1'b0, 0, 0, 4, 1'b1, 2'b11, 2'b00};
        tbl[10] = '{3, 1'b0, 0, 3, 8, 1'b1, 2'b01, 2'b00};
        tbl[11] = '{0, 1'b0, 15, 0, 19, 1'b1, 2'b00, 2'b00};
        tbl[12] = '{2, 1'b0, 0, 15, 19, 1'b0, 2'b00, 2'b00};

        do_reset(2);
        for (int i = 0; i < 13; i++) begin
            run_instr(tbl[i].cls, tbl[i].taken, tbl[i].idly, tbl[i].ddly, lat, rwe, wsel, psel);
            total++;
            if ({lat, rwe, wsel, psel} !== {tbl[i].lat, tbl[i].rwe, tbl[i].wsel, tbl[i].psel}) begin
                bad++;
                $display("FAIL vec%0d got lat=%0d rwe=%b wb=%b pc=%b want lat=%0d rwe=%b wb=%b pc=%b",
                         i, lat, rwe, wsel, psel, tbl[i].lat, tbl[i].rwe, tbl[i].wsel, tbl[i].psel);
            end
        end

        for (int i = 0; i < 40; i++) begin
            run_instr(int'($urandom_range(0, 8)), 1'($urandom_range(0, 1)),
                      int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), lat, rwe, wsel, psel);
        end

        // Counter wrap: sixteen retires from reset return a 4-bit instret to zero.
        do_reset(1);
        for (int i = 0; i < 16; i++) begin
            run_instr(int'($urandom_range(0, 8)), 1'($urandom_range(0, 1)),
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), lat, rwe, wsel, psel);
        end
        check("instret_wrap", 32'(instret), 32'd0);

        // Illegal opcode: no class flag in DECODE.
        do_reset(1);
        flags = '0; bus.imem_ready = 1'b1;
        first_trap = -1; n = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (trap && first_trap < 0) first_trap = k;
            if (first_trap >= 0 && bus.imem_req) n++;
            @(posedge clk); #1;
        end
        check("illegal_trap_cycle", 32'(first_trap), 32'd2);
        check("illegal_cause", 32'(trap_cause), 32'd1);
        check("illegal_no_fetch", 32'(n), 32'd0);

        // Instruction memory never answers.
        do_reset(1);
        flags = 9'd1; bus.imem_ready = 1'b0;
        n = 0;
        for (int k = 0; k < 40 && !trap; k++) begin
            @(negedge clk);
            if (!trap && bus.imem_req) n++;
            @(posedge clk); #1;
        end
        check("imem_timeout_cycles", 32'(n), 32'd16);
        check("imem_timeout_trap", {30'd0, trap, 1'b0} | 32'(trap_cause) << 2, 32'b1010);
        bus.imem_ready = 1'b1;
        n = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (bus.imem_req || !trap) n++;
            @(posedge clk); #1;
        end
        check("trap_sticky", 32'(n), 32'd0);

        // Data memory never answers a load.
        do_reset(1);
        flags = 9'd8; bus.imem_ready = 1'b1; bus.dmem_ready = 1'b0;
        n = 0;
        for (int k = 0; k < 40 && !trap; k++) begin
            @(negedge clk);
            if (!trap && bus.dmem_req) n++;
            @(posedge clk); #1;
        end
        check("dmem_timeout_cycles", 32'(n), 32'd16);
        check("dmem_timeout_cause", {31'd0, trap} | 32'(trap_cause) << 1, 32'b111);

        // Reset in the middle of a pending store.
        do_reset(1);
        run_instr(0, 1'b0, 0, 0, lat, rwe, wsel, psel);
        flags = 9'd4; bus.imem_ready = 1'b1;
        @(posedge clk); #1;
        bus.imem_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        check("store_pending", {30'd0, bus.dmem_req, bus.dmem_we}, 32'b11);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("rst_drops_dmem", {27'd0, bus.dmem_req, instret}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; model_instret = 0;
        flags = 9'd1;
        @(negedge clk);
        check("refetch_after_rst", {27'd0, bus.imem_req, instret}, 32'h10);
        @(posedge clk); #1;
        run_instr(0, 1'b0, 0, 0, lat, rwe, wsel, psel);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
